hdmi_frame_rd_ctrl: RTL and testbench

- Frame-read scheduler for the HDMI output path, in the hdmi_clk domain.
- Keeps the pixel read FIFO that feeds the video driver supplied from frame memory: one frame per vertical sync, issued as burst read requests to the memory arbiter.
- Selects the ping-pong bank holding the most recently completed camera frame.
- Clears the read FIFO at each frame start so the display re-aligns to pixel (0,0).

---
 rtl/hdmi_rd_pkg.sv | 16 +
 rtl/hdmi_bank_sel.sv | 39 +++
 rtl/hdmi_frame_rd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hdmi_frame_rd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_rd_pkg.sv
// Shared FSM encoding and default sizing for the HDMI frame-read scheduler.
package hdmi_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REQ   = 3'd3,
    ST_BURST = 3'd4
  } rd_state_t;

  localparam int unsigned DEF_BURST_LEN   = 64;
  localparam int unsigned DEF_FIFO_DEPTH  = 1024;
  localparam logic [23:0] DEF_BANK_STRIDE = 24'h10_0000;

endpackage

// File: rtl/hdmi_bank_sel.sv
// Tracks the last bank completed by the writer; latches the display bank at frame init.
// A writer completion in the same cycle as init is bypassed straight into the selection.
module hdmi_bank_sel (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wr_frame_done,
  input  logic i_wr_bank,
  input  logic i_init,
  output logic o_bank_next,
  output logic o_rd_bank
);

  logic r_last_bank;
  logic r_bank_valid;
  logic r_rd_bank;
  logic w_bank_next;

  // Until the writer finishes its first frame the display bank simply holds.
  assign w_bank_next = i_wr_frame_done ? i_wr_bank :
                       (r_bank_valid ? r_last_bank : r_rd_bank);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_bank  <= 1'b0;
      r_bank_valid <= 1'b0;
      r_rd_bank    <= 1'b0;
    end else begin
      if (i_wr_frame_done) begin
        r_last_bank  <= i_wr_bank;
        r_bank_valid <= 1'b1;
      end
      if (i_init) r_rd_bank <= w_bank_next;
    end
  end

  assign o_bank_next = w_bank_next;
  assign o_rd_bank   = r_rd_bank;

endmodule

// File: rtl/hdmi_frame_rd_ctrl.sv
// Frame-read scheduler: one frame per vsync as burst reads; sof->fifo_clr 2 cycles, rd_req held until rd_ack.
// Optional macro RD_UNDERFLOW_CNT_EN adds a saturating read-FIFO underflow counter.
module hdmi_frame_rd_ctrl
  import hdmi_rd_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned       LVL_W       = 11,
  parameter logic [ADDR_W-1:0] BANK_STRIDE = ADDR_W'(DEF_BANK_STRIDE)
) (
  input  logic              i_hdmi_clk,
  input  logic              i_rst_n,
  input  logic              i_video_vs,
  input  logic [10:0]       i_h_disp,
  input  logic [10:0]       i_v_disp,
  input  logic              i_wr_frame_done,
  input  logic              i_wr_bank,
  input  logic [LVL_W-1:0]  i_fifo_rd_level,
  output logic              o_fifo_clr,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [7:0]        o_rd_len,
  input  logic              i_rd_ack,
  input  logic              i_rd_done,
  output logic              o_rd_bank,
  output logic              o_busy
`ifdef RD_UNDERFLOW_CNT_EN
  ,
  input  logic              i_fifo_rd_en,
  input  logic              i_fifo_empty,
  output logic [15:0]       o_underflow_cnt
`endif
);

  localparam int unsigned LVL_THR = FIFO_DEPTH - BURST_LEN;

  rd_state_t         r_state;
  logic              r_vs_d;
  logic              r_pend_sof;
  logic [21:0]       r_remain;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [7:0]        r_rd_len;
  logic              r_rd_req;
  logic              r_fifo_clr;
  logic              r_busy;

  logic              w_sof;
  logic              w_init;
  logic              w_bank_next;
  logic [21:0]       w_frame_words;
  logic [7:0]        w_chunk;
  logic              w_lvl_ok;
  logic              w_dim_zero;

  assign w_sof         = i_video_vs & ~r_vs_d;
  assign w_init        = (r_state == ST_INIT);
  assign w_frame_words = 22'(i_h_disp) * 22'(i_v_disp);
  assign w_dim_zero    = (i_h_disp == 11'd0) || (i_v_disp == 11'd0);
  assign w_chunk       = (r_remain >= 22'(BURST_LEN)) ? 8'(BURST_LEN) : r_remain[7:0];
  // Only request when a whole maximum burst is guaranteed to fit.
  assign w_lvl_ok      = (32'(i_fifo_rd_level) <= LVL_THR);

  hdmi_bank_sel u_bank_sel (
    .i_clk           (i_hdmi_clk),
    .i_rst_n         (i_rst_n),
    .i_wr_frame_done (i_wr_frame_done),
    .i_wr_bank       (i_wr_bank),
    .i_init          (w_init),
    .o_bank_next     (w_bank_next),
    .o_rd_bank       (o_rd_bank)
  );

  always_ff @(posedge i_hdmi_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_vs_d     <= 1'b0;
      r_pend_sof <= 1'b0;
      r_remain   <= '0;
      r_addr     <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_req   <= 1'b0;
      r_fifo_clr <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_vs_d     <= i_video_vs;
      r_fifo_clr <= 1'b0;
      if (w_sof) r_pend_sof <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_pend_sof) begin
            r_state    <= ST_INIT;
            r_fifo_clr <= 1'b1;
            r_busy     <= 1'b1;
            r_pend_sof <= w_sof;
          end
        end
        ST_INIT: begin
          r_remain <= w_frame_words;
          r_addr   <= w_bank_next ? BANK_STRIDE : '0;
          if (w_dim_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A pending frame start pre-empts the rest of the current frame.
          if (r_pend_sof) begin
            r_state    <= ST_INIT;
            r_fifo_clr <= 1'b1;
            r_pend_sof <= w_sof;
          end else if (r_remain == 22'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_lvl_ok) begin
            r_state   <= ST_REQ;
            r_rd_req  <= 1'b1;
            r_rd_len  <= w_chunk;
            r_rd_addr <= r_addr;
          end
        end
        ST_REQ: begin
          if (i_rd_ack) begin
            r_rd_req <= 1'b0;
            if (i_rd_done) begin
              r_addr   <= r_addr + ADDR_W'(r_rd_len);
              r_remain <= r_remain - 22'(r_rd_len);
              r_state  <= ST_WAIT;
            end else begin
              r_state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (i_rd_done) begin
            r_addr   <= r_addr + ADDR_W'(r_rd_len);
            r_remain <= r_remain - 22'(r_rd_len);
            r_state  <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_clr = r_fifo_clr;
  assign o_rd_req   = r_rd_req;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_len   = r_rd_len;
  assign o_busy     = r_busy;

`ifdef RD_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge i_hdmi_clk) begin
    if (!i_rst_n) begin
      r_underflow_cnt <= '0;
    end else if (i_fifo_rd_en && i_fifo_empty && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

  assign o_underflow_cnt = r_underflow_cnt;
`endif

endmodule

// File: tb/tb_hdmi_frame_rd_ctrl.sv
// Scoreboard bench: frames are expanded into expected bursts by a reference model; a monitor checks every handshake.
module tb_hdmi_frame_rd_ctrl;

  logic        i_hdmi_clk = 1'b0;
  logic        i_rst_n;
  logic        i_video_vs;
  logic [10:0] i_h_disp;
  logic [10:0] i_v_disp;
  logic        i_wr_frame_done;
  logic        i_wr_bank;
  logic [10:0] i_fifo_rd_level;
  logic        o_fifo_clr;
  logic        o_rd_req;
  logic [23:0] o_rd_addr;
  logic [7:0]  o_rd_len;
  logic        i_rd_ack;
  logic        i_rd_done;
  logic        o_rd_bank;
  logic        o_busy;
`ifdef RD_UNDERFLOW_CNT_EN
  logic        i_fifo_rd_en;
  logic        i_fifo_empty;
  logic [15:0] o_underflow_cnt;
`endif

  always #5 i_hdmi_clk = ~i_hdmi_clk;

  hdmi_frame_rd_ctrl u_dut (
    .i_hdmi_clk      (i_hdmi_clk),
    .i_rst_n         (i_rst_n),
    .i_video_vs      (i_video_vs),
    .i_h_disp        (i_h_disp),
    .i_v_disp        (i_v_disp),
    .i_wr_frame_done (i_wr_frame_done),
    .i_wr_bank       (i_wr_bank),
    .i_fifo_rd_level (i_fifo_rd_level),
    .o_fifo_clr      (o_fifo_clr),
    .o_rd_req        (o_rd_req),
    .o_rd_addr       (o_rd_addr),
    .o_rd_len        (o_rd_len),
    .i_rd_ack        (i_rd_ack),
    .i_rd_done       (i_rd_done),
    .o_rd_bank       (o_rd_bank),
    .o_busy          (o_busy)
`ifdef RD_UNDERFLOW_CNT_EN
    ,
    .i_fifo_rd_en    (i_fifo_rd_en),
    .i_fifo_empty    (i_fifo_empty),
    .o_underflow_cnt (o_underflow_cnt)
`endif
  );

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    logic        bank;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   clr_cnt = 0;
  int   exp_clr = 0;
  int   ack_fix = -1;
  bit   lvl_rand = 0;
  bit   m_last = 0, m_valid = 0, m_bank = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is h*v words from the bank base, cut into chunks of at most 64.
  task automatic model_frame(input int h, input int v, input bit bypass, input bit bp_bank);
    int rem;
    int off;
    exp_t e;
    if (bypass) begin
      m_last  = bp_bank;
      m_valid = 1;
    end
    if (m_valid) m_bank = m_last;
    rem = h * v;
    off = 0;
    while (rem > 0) begin
      e.len  = 8'((rem > 64) ? 64 : rem);
      e.addr = 24'((m_bank ? 32'h10_0000 : 32'h0) + off);
      e.bank = m_bank;
      exp_q.push_back(e);
      off += int'(e.len);
      rem -= int'(e.len);
    end
    exp_clr++;
  endtask

  task automatic tick();
    @(posedge i_hdmi_clk);
    #1;
  endtask

  task automatic wr_done(input bit bank);
    i_wr_frame_done = 1;
    i_wr_bank       = bank;
    tick();
    i_wr_frame_done = 0;
    m_last  = bank;
    m_valid = 1;
  endtask

  task automatic start_frame(input int h, input int v, input bit bypass, input bit bp_bank);
    repeat (2) tick();
    i_h_disp = 11'(h);
    i_v_disp = 11'(v);
    model_frame(h, v, bypass, bp_bank);
    i_video_vs = 1;
    tick();
    chk("clr_lat_early", 32'(o_fifo_clr), 32'd0);
    tick();
    chk("clr_lat_2cyc", 32'(o_fifo_clr), 32'd1);
    if (bypass) begin
      i_wr_frame_done = 1;
      i_wr_bank       = bp_bank;
    end
    tick();
    i_wr_frame_done = 0;
    i_video_vs      = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      if (lvl_rand)
        i_fifo_rd_level = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(961, 1023))
                                                      : 11'($urandom_range(0, 960));
      n++;
    end while (o_busy && n < 3000);
    chk("idle_timeout", 32'(n < 3000), 32'd1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("clr_count", 32'(clr_cnt), 32'(exp_clr));
    chk("rd_bank", 32'(o_rd_bank), 32'(m_bank));
  endtask

  // Arbiter model: random ack delay, sometimes ack and done together.
  initial begin
    int  dly;
    bit  combo;
    i_rd_ack  = 0;
    i_rd_done = 0;
    forever begin
      tick();
      if (o_rd_req) begin
        dly   = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
        combo = (ack_fix < 0) && ($urandom_range(0, 3) == 0);
        repeat (dly) tick();
        i_rd_ack  = 1;
        i_rd_done = combo;
        tick();
        i_rd_ack  = 0;
        i_rd_done = 0;
        if (!combo) begin
          repeat ($urandom_range(0, 4)) tick();
          i_rd_done = 1;
          tick();
          i_rd_done = 0;
        end
      end
    end
  end

  // Monitor: request stability, level gating, handshake scoreboard, clear pulses.
  logic        p_req = 0, p_ack = 0, p_clr = 0;
  logic [23:0] p_addr = '0;
  logic [7:0]  p_len = '0;
  logic [10:0] p_lvl = '0;
  always @(negedge i_hdmi_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (p_req && !p_ack) begin
        chk("req_held", 32'(o_rd_req), 32'd1);
        chk("addr_stable", 32'(o_rd_addr), 32'(p_addr));
        chk("len_stable", 32'(o_rd_len), 32'(p_len));
      end
      if (o_rd_req && !p_req) chk("lvl_gate", 32'(p_lvl <= 11'd960), 32'd1);
      if (o_rd_req && i_rd_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'(o_rd_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr", 32'(o_rd_addr), 32'(e.addr));
          chk("rd_len", 32'(o_rd_len), 32'(e.len));
          chk("req_bank", 32'(o_rd_bank), 32'(e.bank));
        end
      end
      if (o_fifo_clr) begin
        clr_cnt++;
        chk("clr_one_cycle", 32'(p_clr), 32'd0);
      end
    end
    p_req  = o_rd_req;
    p_ack  = i_rd_ack;
    p_clr  = o_fifo_clr;
    p_addr = o_rd_addr;
    p_len  = o_rd_len;
    p_lvl  = i_fifo_rd_level;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst_n = 0;
    i_video_vs = 0;
    i_h_disp = 0;
    i_v_disp = 0;
    i_wr_frame_done = 0;
    i_wr_bank = 0;
    i_fifo_rd_level = 0;
`ifdef RD_UNDERFLOW_CNT_EN
    i_fifo_rd_en = 0;
    i_fifo_empty = 0;
`endif
    repeat (3) tick();
    chk("rst_clr", 32'(o_fifo_clr), 32'd0);
    chk("rst_req", 32'(o_rd_req), 32'd0);
    chk("rst_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_len", 32'(o_rd_len), 32'd0);
    chk("rst_bank", 32'(o_rd_bank), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
`ifdef RD_UNDERFLOW_CNT_EN
    chk("rst_uf", 32'(o_underflow_cnt), 32'd0);
`endif
    i_rst_n = 1;
    tick();

    // 128 words: 0/64 then 64/64
    start_frame(16, 8, 0, 0);
    wait_idle();
    // 100 words: 64 then 36
    start_frame(10, 10, 0, 0);
    wait_idle();
    chk("busy_drop", 32'(o_busy), 32'd0);
    // zero dimension: clear only, no bursts
    start_frame(0, 5, 0, 0);
    wait_idle();

    // level gate boundary
    i_fifo_rd_level = 11'd961;
    start_frame(4, 4, 0, 0);
    repeat (6) tick();
    chk("no_req_961", 32'(o_rd_req), 32'd0);
    i_fifo_rd_level = 11'd960;
    tick();
    chk("req_at_960", 32'(o_rd_req), 32'd1);
    wait_idle();
    i_fifo_rd_level = 0;

    // bank selection, then a second frame with no new writer completion
    wr_done(1);
    start_frame(16, 8, 0, 0);
    wait_idle();
    chk("bank1_sel", 32'(o_rd_bank), 32'd1);
    start_frame(3, 3, 0, 0);
    wait_idle();
    chk("bank1_hold", 32'(o_rd_bank), 32'd1);
    // writer completion landing in the init cycle
    start_frame(5, 2, 1, 0);
    wait_idle();

    // frame start while a request waits for a slow ack
    ack_fix = 5;
    start_frame(16, 8, 0, 0);
    n = 0;
    while (!o_rd_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(o_rd_req), 32'd1);
    i_video_vs = 1;
    void'(exp_q.pop_back());
    model_frame(16, 8, 0, 0);
    repeat (2) tick();
    i_video_vs = 0;
    chk("no_clr_during_req", 32'(clr_cnt), 32'(exp_clr - 1));
    chk("req_still_up", 32'(o_rd_req), 32'd1);
    wait_idle();
    ack_fix = -1;

    // randomized frames
    lvl_rand = 1;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) wr_done(1'($urandom_range(0, 1)));
      start_frame(int'($urandom_range(0, 40)), int'($urandom_range(1, 12)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    lvl_rand = 0;

`ifdef RD_UNDERFLOW_CNT_EN
    i_fifo_rd_en = 1;
    i_fifo_empty = 1;
    repeat (3) tick();
    i_fifo_empty = 0;
    tick();
    i_fifo_rd_en = 0;
    chk("uf_cnt3", 32'(o_underflow_cnt), 32'd3);
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    chk("uf_rst", 32'(o_underflow_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
